// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline.
// Fetch-stage bundle and the canonical NOP encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between imem responses and decode.
// Clear overrides push and pop in the same cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i & ~clear_i
                 & (~full_o | pop_i);
  assign do_pop  = pop_i & ~clear_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push)
            - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem requests and buffers
// responses for decode; ImemReqValidF is combinational on StallD/PCSrcE.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            ImemReqValidF,
  output logic [XLEN-1:0] ImemAddrF,
  input  logic            ImemReqReadyF,
  input  logic            ImemRespValidF,
  input  logic [XLEN-1:0] ImemRdataF,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic [XLEN-1:0] rpc_q [QDEPTH];
  logic [AW-1:0]   rwr_q, rrd_q;

  fetch_entry_t    q_head;
  fetch_entry_t    q_data;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic            q_push;

  logic            consume;
  logic            accept;
  logic            drop;
  logic [SW-1:0]   budget;

  assign consume = ValidD & ~StallD;

  // Outstanding plus buffered must fit the queue, so responses never stall.
  assign budget = SW'(outs_q) + SW'(q_count)
                - SW'(consume);

  assign ImemReqValidF = reset_n & ~PCSrcE
                       & (budget < SW'(QDEPTH))
                       & ~(q_full & ~consume);
  assign ImemAddrF = pc_q;
  assign accept    = ImemReqValidF & ImemReqReadyF;

  assign drop   = ImemRespValidF
                & ((disc_q != '0) | PCSrcE);
  assign q_push = ImemRespValidF & ~drop;
  assign q_data = '{instr: ImemRdataF,
                    pc:    rpc_q[rrd_q]};

  assign outs_d = outs_q + CW'(accept)
                - CW'(ImemRespValidF);

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      PCSrcE:  pc_d = PCTargetE & ~32'h3;
      accept:  pc_d = pc_q + 32'd4;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    disc_d = disc_q;
    if (PCSrcE)
      disc_d = outs_d;
    else if (disc_q != '0)
      disc_d = disc_q - CW'(ImemRespValidF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      outs_q <= '0;
      disc_q <= '0;
      rwr_q  <= '0;
      rrd_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      outs_q <= outs_d;
      disc_q <= disc_d;
      if (accept)
        rwr_q <= rwr_q + AW'(1);
      if (ImemRespValidF)
        rrd_q <= rrd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rpc_q[rwr_q] <= pc_q;
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (PCSrcE),
    .push_i  (q_push),
    .data_i  (q_data),
    .pop_i   (consume),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign ValidD   = ~q_empty;
  assign InstrD   = q_empty ? NOP_INSTR
                            : q_head.instr;
  assign PCD      = q_empty ? '0 : q_head.pc;
  assign PCPlus4D = PCD + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable
// in-order instruction memory model.
module tb_fetch_stage;

  localparam int QDEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ImemReqValidF;
  logic [31:0] ImemAddrF;
  logic        ImemReqReadyF;
  logic        ImemRespValidF;
  logic [31:0] ImemRdataF;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ImemReqValidF  (ImemReqValidF),
    .ImemAddrF      (ImemAddrF),
    .ImemReqReadyF  (ImemReqReadyF),
    .ImemRespValidF (ImemRespValidF),
    .ImemRdataF     (ImemRdataF),
    .StallD         (StallD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .ValidD         (ValidD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(
    input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          lat = 1;
  int          rdy_mode = 0;
  logic [15:0] rdy_pat = 16'b1011_0110_1101_0011;
  logic        m_acc, m_rsp;
  logic [31:0] m_addr;
  logic [31:0] cons[$];

  // Memory: capture handshakes late in the cycle, update after the edge.
  initial begin
    ImemRespValidF = 1'b0;
    ImemRdataF     = '0;
    ImemReqReadyF  = 1'b1;
    forever begin
      @(negedge clk); #3;
      m_acc  = ImemReqValidF & ImemReqReadyF;
      m_addr = ImemAddrF;
      m_rsp  = ImemRespValidF;
      @(posedge clk); #1;
      cyc++;
      if (!reset_n) pend.delete();
      else begin
        if (m_rsp && pend.size() > 0)
          void'(pend.pop_front());
        if (m_acc) begin
          pend.push_back('{addr: m_addr,
                           due: cyc + lat - 1});
          chk("outs_le_qdepth",
              32'(pend.size() <= QDEPTH), 1);
        end
      end
      ImemRespValidF = 1'b0;
      ImemRdataF     = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ImemRespValidF = 1'b1;
        ImemRdataF     = instr_of(pend[0].addr);
      end
      ImemReqReadyF = (rdy_mode == 0) ? 1'b1
                    : rdy_pat[4'(cyc)];
    end
  end

  // Decode-side monitor: content integrity and consumed-PC log.
  initial begin
    forever begin
      @(negedge clk); #4;
      if (ValidD) begin
        chk("instr_match", InstrD, instr_of(PCD));
        chk("pcplus4", PCPlus4D, PCD + 32'd4);
        if (!StallD) cons.push_back(PCD);
      end else begin
        chk("nop_when_idle", InstrD, NOP);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_validd", 32'(ValidD), 0);
    chk("rst_instrd", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_pcplus4", PCPlus4D, 4);
    chk("rst_reqvalid", 32'(ImemReqValidF), 0);
    @(negedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
  endtask

  task automatic check_cons(input string tag,
                            input int n);
    chk({tag, "_count"},
        32'(cons.size() >= n), 1);
    for (int i = 0; i < n; i++)
      if (i < cons.size())
        chk(tag, cons[i], 32'(4 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    reset_n   = 1'b0;
    StallD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("init_validd", 32'(ValidD), 0);
    chk("init_instrd", InstrD, NOP);
    chk("init_pcd", PCD, 0);
    chk("init_pcplus4", PCPlus4D, 4);
    chk("init_reqvalid", 32'(ImemReqValidF), 0);

    // Free run, then a 4-cycle stall at PCD=8.
    cons.delete();
    #1 reset_n = 1'b1;
    #1;
    chk("rel_reqvalid", 32'(ImemReqValidF), 1);
    chk("rel_addr", ImemAddrF, 0);
    @(negedge clk); #1;
    chk("c2_validd", 32'(ValidD), 0);
    chk("c2_addr", ImemAddrF, 4);
    @(negedge clk); #1;
    chk("c3_validd", 32'(ValidD), 1);
    chk("c3_pcd", PCD, 0);
    @(negedge clk); #1;
    chk("c4_pcd", PCD, 4);
    @(negedge clk);
    StallD = 1'b1;
    #1;
    chk("stall_pcd", PCD, 8);
    chk("stall_reqvalid", 32'(ImemReqValidF), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall_hold_pcd", PCD, 8);
      chk("stall_hold_valid", 32'(ValidD), 1);
      chk("stall_hold_req",
          32'(ImemReqValidF), 0);
    end
    @(negedge clk);
    StallD = 1'b0;
    #1;
    chk("unstall_pcd", PCD, 8);
    chk("unstall_req", 32'(ImemReqValidF), 1);
    chk("unstall_addr", ImemAddrF, 16);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("no_bubble", 32'(ValidD), 1);
    end
    #5;
    check_cons("stall_seq", 11);

    // Redirect with two requests outstanding, latency 3.
    lat = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0100;
    #1;
    chk("redir_reqvalid", 32'(ImemReqValidF), 0);
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    chk("redir_r1_validd", 32'(ValidD), 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (ValidD) found = 1'b1;
    end
    chk("redir_found", 32'(found), 1);
    chk("redir_pcd", PCD, 32'h100);
    chk("redir_pcplus4", PCPlus4D, 32'h104);
    chk("redir_instr", InstrD, instr_of(32'h100));

    // Redirect together with StallD and a live response.
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("rs_pre_pcd", PCD, 8);
    StallD    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0203;
    #1;
    chk("rs_reqvalid", 32'(ImemReqValidF), 0);
    @(negedge clk);
    StallD = 1'b0;
    PCSrcE = 1'b0;
    #1;
    chk("rs_r1_validd", 32'(ValidD), 0);
    chk("rs_r1_req", 32'(ImemReqValidF), 1);
    chk("rs_r1_addr", ImemAddrF, 32'h200);
    @(negedge clk); #1;
    chk("rs_r2_validd", 32'(ValidD), 0);
    @(negedge clk); #1;
    chk("rs_r3_validd", 32'(ValidD), 1);
    chk("rs_r3_pcd", PCD, 32'h200);

    // Backpressured memory, latency 3.
    lat      = 3;
    rdy_mode = 1;
    do_reset();
    cons.delete();
    for (int i = 0; i < 400 && cons.size() < 12; i++)
      @(negedge clk);
    check_cons("bp_seq", 12);

    // Asynchronous reset mid-stream, then refetch from 0.
    lat      = 1;
    rdy_mode = 0;
    do_reset();
    cons.delete();
    #1;
    chk("rr_reqvalid", 32'(ImemReqValidF), 1);
    chk("rr_addr", ImemAddrF, 0);
    for (int i = 0; i < 20 && cons.size() < 4; i++)
      @(negedge clk);
    #5;
    check_cons("rr_seq", 4);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
